// File: rtl/serial_subtractor_pkg.sv
// Shared types and helpers for the bit-serial subtractor.
package sub_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } sub_state_t;

  // Cycle-counter width: $clog2(n), never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/serial_subtractor_fs_cell.sv
// One-bit dataflow full subtractor: d = a - b - bin, with borrow out.
module fs_cell (
  input  logic a_i,
  input  logic b_i,
  input  logic bin_i,
  output logic d_o,
  output logic bout_o
);

  assign d_o    = a_i ^ b_i ^ bin_i;
  assign bout_o = (~a_i & bin_i) | (~a_i & b_i) | (b_i & bin_i);

endmodule

// File: rtl/serial_subtractor.sv
// Multi-cycle a - b - borr_in, BPC bits per clock through a chain of fs_cell slices.
module serial_subtractor
  import sub_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned BPC   = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             borr_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borr_out,
  output logic             ovf,
  output logic             zero
);

  localparam int unsigned N  = WIDTH / BPC;
  localparam int unsigned CW = cnt_width(N);

  if ((WIDTH < 2) || (BPC == 0) || ((WIDTH % BPC) != 0)) begin : g_bad_param
    $error("serial_subtractor: BPC must divide WIDTH and WIDTH must be >= 2");
  end

  sub_state_t       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             borr_q, borr_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             borr_out_q, borr_out_d;
  logic             ovf_q, ovf_d;
  logic             zero_q, zero_d;

  logic [BPC:0]     chain_b;
  logic [BPC-1:0]   chain_d;
  logic [WIDTH-1:0] res_next;
  logic             last_cycle;

  assign chain_b[0] = borr_q;

  for (genvar i = 0; i < BPC; i++) begin : g_cell
    fs_cell u_cell (
      .a_i    (a_q[i]),
      .b_i    (b_q[i]),
      .bin_i  (chain_b[i]),
      .d_o    (chain_d[i]),
      .bout_o (chain_b[i+1])
    );
  end

  // New diff bits enter at the MSB end so the LSB chunk lands at bit 0 after N cycles.
  assign res_next   = WIDTH'({chain_d, res_q} >> BPC);
  assign last_cycle = (cnt_q == CW'(N - 1));

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    a_d        = a_q;
    b_d        = b_q;
    res_d      = res_q;
    borr_d     = borr_q;
    diff_d     = diff_q;
    borr_out_d = borr_out_q;
    ovf_d      = ovf_q;
    zero_d     = zero_q;

    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          borr_d  = borr_in;
          res_d   = '0;
          cnt_d   = '0;
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        a_d    = a_q >> BPC;
        b_d    = b_q >> BPC;
        res_d  = res_next;
        borr_d = chain_b[BPC];
        cnt_d  = cnt_q + 1'b1;
        if (last_cycle) begin
          // On the final chunk the operand MSBs sit at bit BPC-1 of the shift regs.
          diff_d     = res_next;
          borr_out_d = chain_b[BPC];
          ovf_d      = (a_q[BPC-1] != b_q[BPC-1]) && (res_next[WIDTH-1] != a_q[BPC-1]);
          zero_d     = (res_next == '0);
          state_d    = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      a_q        <= '0;
      b_q        <= '0;
      res_q      <= '0;
      borr_q     <= 1'b0;
      diff_q     <= '0;
      borr_out_q <= 1'b0;
      ovf_q      <= 1'b0;
      zero_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      a_q        <= a_d;
      b_q        <= b_d;
      res_q      <= res_d;
      borr_q     <= borr_d;
      diff_q     <= diff_d;
      borr_out_q <= borr_out_d;
      ovf_q      <= ovf_d;
      zero_q     <= zero_d;
    end
  end

  assign busy     = (state_q == RUN);
  assign done     = (state_q == DONE);
  assign diff     = diff_q;
  assign borr_out = borr_out_q;
  assign ovf      = ovf_q;
  assign zero     = zero_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Bench for serial_subtractor: directed corners, random ops and an exhaustive W=4 sweep.
module tb_serial_subtractor;

  typedef struct packed {
    logic       borr;
    logic       ovf;
    logic       zero;
    logic [7:0] diff;
  } res_t;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [7:0] a, b;
  logic       bin;
  logic       busy, done, borr_out, ovf, zero;
  logic [7:0] diff;

  logic       start4 [3];
  logic [3:0] a4, b4;
  logic       bin4;
  logic       busy4 [3];
  logic       done4 [3];
  logic [3:0] diff4 [3];
  logic       borr4 [3];
  logic       ovf4 [3];
  logic       zero4 [3];

  int vectors;
  int miscompares;

  serial_subtractor #(.WIDTH(8), .BPC(1)) u_dut8 (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .a        (a),
    .b        (b),
    .borr_in  (bin),
    .busy     (busy),
    .done     (done),
    .diff     (diff),
    .borr_out (borr_out),
    .ovf      (ovf),
    .zero     (zero)
  );

  serial_subtractor #(.WIDTH(4), .BPC(1)) u_dut4_b1 (
    .clk(clk), .rst_n(rst_n), .start(start4[0]), .a(a4), .b(b4), .borr_in(bin4),
    .busy(busy4[0]), .done(done4[0]), .diff(diff4[0]), .borr_out(borr4[0]),
    .ovf(ovf4[0]), .zero(zero4[0])
  );

  serial_subtractor #(.WIDTH(4), .BPC(2)) u_dut4_b2 (
    .clk(clk), .rst_n(rst_n), .start(start4[1]), .a(a4), .b(b4), .borr_in(bin4),
    .busy(busy4[1]), .done(done4[1]), .diff(diff4[1]), .borr_out(borr4[1]),
    .ovf(ovf4[1]), .zero(zero4[1])
  );

  serial_subtractor #(.WIDTH(4), .BPC(4)) u_dut4_b4 (
    .clk(clk), .rst_n(rst_n), .start(start4[2]), .a(a4), .b(b4), .borr_in(bin4),
    .busy(busy4[2]), .done(done4[2]), .diff(diff4[2]), .borr_out(borr4[2]),
    .ovf(ovf4[2]), .zero(zero4[2])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: plain integer arithmetic on unsigned and two's-complement views.
  function automatic res_t model(input int w, input int ua, input int ub, input int ubin);
    res_t r;
    int   m, u, sa, sb, s, dv;
    m  = 1 << w;
    u  = ua - ub - ubin;
    sa = (ua >= m / 2) ? ua - m : ua;
    sb = (ub >= m / 2) ? ub - m : ub;
    s  = sa - sb - ubin;
    dv = (u < 0) ? u + m : u;
    r.borr = (u < 0);
    r.ovf  = (s < -(m / 2)) || (s >= m / 2);
    r.zero = (dv == 0);
    r.diff = 8'(dv);
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Launch one op on the 8-bit DUT and wait (bounded) for done.
  task automatic op8(input logic [7:0] ia, input logic [7:0] ib, input logic ibin,
                     output int lat, output int busy_cnt);
    a = ia; b = ib; bin = ibin; start = 1'b1;
    tick();
    start = 1'b0;
    a = 8'($urandom); b = 8'($urandom); bin = 1'($urandom);
    lat = 1; busy_cnt = 0;
    while (done !== 1'b1 && lat < 40) begin
      if (busy === 1'b1) busy_cnt++;
      tick();
      lat++;
    end
  endtask

  task automatic test_reset_state();
    vectors++;
    if ({busy, done, diff, borr_out, ovf, zero} !== 12'h000) begin
      miscompares++;
      $display("FAIL reset_state got %h want 000", {busy, done, diff, borr_out, ovf, zero});
    end
  endtask

  task automatic test_basic();
    int lat, bc;
    op8(8'h05, 8'h03, 1'b0, lat, bc);
    vectors++;
    if (lat !== 9) begin
      miscompares++;
      $display("FAIL basic_latency got %0d want 9", lat);
    end
    vectors++;
    if ({borr_out, ovf, zero, diff} !== {3'b000, 8'h02}) begin
      miscompares++;
      $display("FAIL basic_result got %b_%h want 000_02", {borr_out, ovf, zero}, diff);
    end
    vectors++;
    if (bc !== 8) begin
      miscompares++;
      $display("FAIL basic_busy_cycles got %0d want 8", bc);
    end
    tick();
    vectors++;
    if (done !== 1'b0) begin
      miscompares++;
      $display("FAIL basic_done_width got %b want 0", done);
    end
  endtask

  task automatic test_corners();
    logic [7:0] ta   [4] = '{8'h03, 8'h80, 8'h00, 8'h2A};
    logic [7:0] tb   [4] = '{8'h05, 8'h01, 8'h00, 8'h2A};
    logic       tbin [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
    res_t       texp [4] = '{'{1'b1, 1'b0, 1'b0, 8'hFE}, '{1'b0, 1'b1, 1'b0, 8'h7F},
                             '{1'b1, 1'b0, 1'b0, 8'hFF}, '{1'b0, 1'b0, 1'b1, 8'h00}};
    int lat, bc;
    for (int i = 0; i < 4; i++) begin
      op8(ta[i], tb[i], tbin[i], lat, bc);
      vectors++;
      if ({borr_out, ovf, zero, diff} !== texp[i]) begin
        miscompares++;
        $display("FAIL corner%0d got %h want %h", i, {borr_out, ovf, zero, diff}, texp[i]);
      end
      tick();
    end
  endtask

  task automatic test_reset_midrun();
    a = 8'h80; b = 8'h01; bin = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    #2 rst_n = 1'b0;
    #1;
    vectors++;
    if ({busy, done, diff, borr_out, ovf, zero} !== 12'h000) begin
      miscompares++;
      $display("FAIL async_reset got %h want 000", {busy, done, diff, borr_out, ovf, zero});
    end
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_start_ignored();
    int lat;
    a = 8'h10; b = 8'h01; bin = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    a = 8'hFF; b = 8'h00; bin = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    lat = 4;
    while (done !== 1'b1 && lat < 40) begin
      tick();
      lat++;
    end
    vectors++;
    if (lat !== 9 || diff !== 8'h0F || borr_out !== 1'b0) begin
      miscompares++;
      $display("FAIL start_ignored lat %0d diff %h borr %b want 9 0f 0", lat, diff, borr_out);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    int gap;
    a = 8'h40; b = 8'h41; bin = 1'b0; start = 1'b1;
    tick();
    a = 8'h33; b = 8'h11; bin = 1'b1;
    gap = 1;
    while (done !== 1'b1 && gap < 40) begin
      tick();
      gap++;
    end
    vectors++;
    if (gap !== 9 || diff !== 8'hFF || borr_out !== 1'b1) begin
      miscompares++;
      $display("FAIL b2b_first lat %0d diff %h borr %b want 9 ff 1", gap, diff, borr_out);
    end
    tick();
    start = 1'b0;
    vectors++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      miscompares++;
      $display("FAIL b2b_rebusy busy %b done %b want 1 0", busy, done);
    end
    gap = 1;
    while (done !== 1'b1 && gap < 40) begin
      tick();
      gap++;
    end
    vectors++;
    if (gap !== 9 || diff !== 8'h21) begin
      miscompares++;
      $display("FAIL b2b_second period %0d diff %h want 9 21", gap, diff);
    end
    tick();
  endtask

  task automatic test_abort();
    int lat, bc, seen;
    op8(8'h03, 8'h05, 1'b0, lat, bc);
    tick();
    a = 8'h20; b = 8'h10; bin = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    vectors++;
    if ({busy, done, diff, borr_out, ovf, zero} !== 12'h000) begin
      miscompares++;
      $display("FAIL abort_reset got %h want 000", {busy, done, diff, borr_out, ovf, zero});
    end
    tick();
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      if (done === 1'b1) seen++;
      tick();
    end
    vectors++;
    if (seen !== 0) begin
      miscompares++;
      $display("FAIL abort_no_done got %0d pulses want 0", seen);
    end
    op8(8'h20, 8'h10, 1'b0, lat, bc);
    vectors++;
    if (lat !== 9 || diff !== 8'h10 || borr_out !== 1'b0) begin
      miscompares++;
      $display("FAIL abort_fresh lat %0d diff %h borr %b want 9 10 0", lat, diff, borr_out);
    end
    tick();
  endtask

  task automatic test_random();
    int lat, bc;
    logic [7:0] ra, rb;
    logic rbin;
    res_t e;
    for (int i = 0; i < 40; i++) begin
      ra = 8'($urandom); rb = 8'($urandom); rbin = 1'($urandom);
      e = model(8, int'(ra), int'(rb), int'(rbin));
      op8(ra, rb, rbin, lat, bc);
      vectors++;
      if (lat !== 9 || {borr_out, ovf, zero, diff} !== e) begin
        miscompares++;
        $display("FAIL random %h-%h-%b lat %0d got %h want %h", ra, rb, rbin, lat,
                 {borr_out, ovf, zero, diff}, e);
      end
      if ($urandom_range(1) == 1) tick();
    end
  endtask

  task automatic test_w4_sweep();
    int n, lat, bc;
    res_t e;
    for (int k = 0; k < 3; k++) begin
      n = (k == 0) ? 4 : (k == 1) ? 2 : 1;
      for (int c = 0; c < 512; c++) begin
        a4 = 4'(c); b4 = 4'(c >> 4); bin4 = 1'(c >> 8);
        e = model(4, c & 15, (c >> 4) & 15, (c >> 8) & 1);
        start4[k] = 1'b1;
        tick();
        start4[k] = 1'b0;
        a4 = 4'($urandom); b4 = 4'($urandom); bin4 = 1'($urandom);
        lat = 1; bc = 0;
        while (done4[k] !== 1'b1 && lat < 20) begin
          if (busy4[k] === 1'b1) bc++;
          tick();
          lat++;
        end
        vectors++;
        if (lat !== n + 1 || bc !== n) begin
          miscompares++;
          $display("FAIL w4_timing bpc_idx %0d c %0d lat %0d busy %0d want %0d %0d",
                   k, c, lat, bc, n + 1, n);
        end
        vectors++;
        if ({borr4[k], ovf4[k], zero4[k], diff4[k]} !== {e.borr, e.ovf, e.zero, e.diff[3:0]}) begin
          miscompares++;
          $display("FAIL w4_result bpc_idx %0d c %0d got %b want %b", k, c,
                   {borr4[k], ovf4[k], zero4[k], diff4[k]},
                   {e.borr, e.ovf, e.zero, e.diff[3:0]});
        end
        tick();
        vectors++;
        if (done4[k] !== 1'b0) begin
          miscompares++;
          $display("FAIL w4_done_width bpc_idx %0d c %0d got %b want 0", k, c, done4[k]);
        end
      end
    end
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    rst_n = 1'b0;
    start = 1'b0; a = '0; b = '0; bin = 1'b0;
    for (int k = 0; k < 3; k++) start4[k] = 1'b0;
    a4 = '0; b4 = '0; bin4 = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    test_reset_state();
    test_basic();
    test_corners();
    test_reset_midrun();
    test_start_ignored();
    test_back_to_back();
    test_abort();
    test_random();
    test_w4_sweep();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
